// File: rtl/uart_matrix_loader_pkg.sv
// ---------------------------------------------------------------------------
// uart_matrix_loader_pkg
// Shared types and constants for the UART matrix loader:
//   - loader_state_t : loader FSM states (IDLE/RECEIVING/STORE/DONE)
//   - rx_state_t     : UART receiver states
//   - baud table     : BAUD_SEL -> baud rate, plus oversample divider helper
//   - frame layout   : START_BIT / STOP_BIT positions in the 10-bit frame
// ---------------------------------------------------------------------------
package uart_matrix_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVING,
        ST_STORE,
        ST_DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;
    localparam int unsigned OVERSAMPLE  = 8;

    localparam int unsigned START_BIT = 0;
    localparam int unsigned STOP_BIT  = 9;
    localparam int unsigned FRAME_W   = 10;

    function automatic int unsigned baud_rate(input int sel);
        case (sel)
            1:       return BAUD_19200;
            2:       return BAUD_57600;
            3:       return BAUD_115200;
            default: return BAUD_9600;
        endcase
    endfunction

    // Clocks per oversample tick; clamped to 1 so a tiny clock still ticks.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int sel);
        int unsigned d;
        d = clk_hz / (baud_rate(sel) * OVERSAMPLE);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_matrix_loader_if.sv
// ---------------------------------------------------------------------------
// uart_matrix_loader_if
// Read port of the matrix memory.
//   read_en      : read strobe (data appears one clk later)
//   read_address : element index; out-of-range indices read as 0
//   data_out     : registered read data
// master = downstream consumer, slave = uart_matrix_loader.
// ---------------------------------------------------------------------------
interface uart_matrix_loader_if;
    logic        read_en;
    logic [31:0] read_address;
    logic [7:0]  data_out;

    modport master (output read_en, output read_address, input data_out);
    modport slave  (input read_en, input read_address, output data_out);
endinterface

// File: rtl/uart_matrix_loader_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver with 8x oversample tick generator and 2-flop synchroniser.
//   clk, rst  : clock, async active-high reset
//   rx_data   : serial input, idles high
//   rx_busy   : high from start-edge detect until the stop-bit sample
//   frame     : {stop, data[7:0], start}, data LSB first
//   frame_ok  : stop bit sampled as 1
// ---------------------------------------------------------------------------
module uart_rx_core
    import uart_matrix_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int          BAUD_SEL    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_data,
    output logic               rx_busy,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_ok
);

    localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD_SEL);

    logic [31:0]        r_div_cnt;
    logic               w_tick;
    logic [1:0]         r_sync;
    logic               r_rx_d;
    logic               w_rx;
    logic               w_fall;
    rx_state_t          r_state, w_state_nx;
    logic [2:0]         r_tcnt, w_tcnt_nx;
    logic [2:0]         r_bit, w_bit_nx;
    logic [FRAME_W-1:0] r_frame, w_frame_nx;

    assign w_tick = (r_div_cnt == 32'(DIV - 1));
    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_d & ~w_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx_data};
            r_rx_d <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_tcnt  <= '0;
            r_bit   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tcnt  <= w_tcnt_nx;
            r_bit   <= w_bit_nx;
            r_frame <= w_frame_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tcnt_nx  = r_tcnt;
        w_bit_nx   = r_bit;
        w_frame_nx = r_frame;
        case (r_state)
            RX_IDLE: begin
                // Frame is cleared on every start so a false start reads as stop=0.
                if (w_fall) begin
                    w_state_nx = RX_START;
                    w_tcnt_nx  = '0;
                    w_bit_nx   = '0;
                    w_frame_nx = '0;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_tcnt == 3'd3) begin
                        if (w_rx) begin
                            w_state_nx = RX_IDLE;
                        end else begin
                            w_frame_nx[START_BIT] = w_rx;
                            w_state_nx = RX_DATA;
                            w_tcnt_nx  = '0;
                        end
                    end else begin
                        w_tcnt_nx = r_tcnt + 3'd1;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_tcnt_nx = r_tcnt + 3'd1;
                    if (r_tcnt == 3'd7) begin
                        // Shift in from the top: after 8 bits the first lands at bit 1.
                        w_frame_nx[STOP_BIT-1:START_BIT+1] = {w_rx, r_frame[STOP_BIT-1:START_BIT+2]};
                        if (r_bit == 3'd7) begin
                            w_state_nx = RX_STOP;
                        end else begin
                            w_bit_nx = r_bit + 3'd1;
                        end
                    end
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_tcnt_nx = r_tcnt + 3'd1;
                    if (r_tcnt == 3'd7) begin
                        w_frame_nx[STOP_BIT] = w_rx;
                        w_state_nx = RX_IDLE;
                    end
                end
            end
            default: w_state_nx = RX_IDLE;
        endcase
    end

    assign rx_busy  = (r_state != RX_IDLE);
    assign frame    = r_frame;
    assign frame_ok = r_frame[STOP_BIT];

endmodule

// File: rtl/uart_matrix_loader.sv
// ---------------------------------------------------------------------------
// uart_matrix_loader
// Loads ROW*COLUMN bytes received over UART into a byte memory and flags
// completion; the memory is readable through a registered read port.
//   clk, rst          : clock, async active-high reset
//   rx_data           : UART serial input
//   write_en          : permits accepting/storing bytes
//   written_completed : high while the matrix is full
//   rd (slave)        : read_en, read_address[31:0] -> data_out[7:0]
// ---------------------------------------------------------------------------
module uart_matrix_loader
    import uart_matrix_loader_pkg::*;
#(
    parameter int unsigned ROW         = 2,
    parameter int unsigned COLUMN      = 2,
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int          BAUD_SEL    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 write_en,
    output logic                 written_completed,
    uart_matrix_loader_if.slave  rd
);

    localparam int unsigned TOTAL = ROW * COLUMN;
    localparam int unsigned AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic               w_rx_busy;
    logic [FRAME_W-1:0] w_frame;
    logic               w_frame_ok;
    logic               w_frame_good;
    logic               r_busy_d;
    logic               w_busy_rise;
    logic               w_busy_fall;
    logic               w_store;
    loader_state_t      r_state, w_state_nx;
    logic [31:0]        r_count;
    logic [7:0]         r_mem [TOTAL];
    logic [7:0]         r_data_out;

    uart_rx_core #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_SEL    (BAUD_SEL)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_busy  (w_rx_busy),
        .frame    (w_frame),
        .frame_ok (w_frame_ok)
    );

    // Only a start seen with write_en high opens a byte; mid-frame enables are ignored.
    assign w_busy_rise  = w_rx_busy & ~r_busy_d;
    assign w_busy_fall  = ~w_rx_busy & r_busy_d;
    assign w_frame_good = w_frame_ok & w_frame[STOP_BIT] & ~w_frame[START_BIT];

    always_comb begin
        w_state_nx = r_state;
        w_store    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_busy_rise && write_en) w_state_nx = ST_RECEIVING;
            end
            ST_RECEIVING: begin
                if (w_busy_fall) w_state_nx = w_frame_good ? ST_STORE : ST_IDLE;
            end
            ST_STORE: begin
                w_store    = 1'b1;
                w_state_nx = (r_count >= 32'(TOTAL - 1)) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: w_state_nx = ST_DONE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy_d <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_busy_d <= w_rx_busy;
            if (w_store) r_count <= r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TOTAL; i++) r_mem[i] <= '0;
            r_data_out <= '0;
        end else begin
            if (w_store && write_en) r_mem[r_count[AW-1:0]] <= w_frame[STOP_BIT-1:START_BIT+1];
            if (rd.read_en) begin
                r_data_out <= (rd.read_address < 32'(TOTAL)) ? r_mem[rd.read_address[AW-1:0]] : '0;
            end
        end
    end

    assign rd.data_out       = r_data_out;
    assign written_completed = (r_state == ST_DONE);

endmodule

// File: tb/tb_uart_matrix_loader.sv
module tb_uart_matrix_loader;
    import uart_matrix_loader_pkg::*;

    localparam int unsigned CLK_HZ   = 768_000;
    localparam int unsigned TOTAL    = 4;
    localparam int unsigned BIT_CLKS = 80;

    logic clk = 1'b0;
    logic rst;
    logic rx_data;
    logic write_en;
    logic wc;

    uart_matrix_loader_if rd_if ();

    uart_matrix_loader #(
        .ROW         (2),
        .COLUMN      (2),
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_SEL    (0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_data           (rx_data),
        .write_en          (write_en),
        .written_completed (wc),
        .rd                (rd_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: list of accepted bytes, filled in arrival order.
    logic [7:0]  m_mem [TOTAL];
    int unsigned m_cnt;
    logic        m_done;

    function automatic void model_reset();
        for (int i = 0; i < TOTAL; i++) m_mem[i] = 8'h00;
        m_cnt  = 0;
        m_done = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic stop, input logic we);
        if (!m_done && we && stop) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == TOTAL) m_done = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_read(input logic [31:0] addr);
        return (addr < TOTAL) ? m_mem[addr[1:0]] : 8'h00;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       we;
        logic       exp_wc;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic [7:0] d, input logic stop, input logic we, input logic exp_wc);
        vec_t v;
        v.d = d; v.stop = stop; v.we = we; v.exp_wc = exp_wc;
        return v;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk); rx_data = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_data = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_data = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rx_data = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic apply(input logic [7:0] d, input logic stop, input logic we);
        write_en = we;
        send_frame(d, stop);
        model_frame(d, stop, we);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply(vecs[i].d, vecs[i].stop, vecs[i].we);
            check($sformatf("wc_vec%0d", i), 32'(wc), 32'(vecs[i].exp_wc));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_data = 1'b1; rd_if.read_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, input string name);
        rd_if.read_en = 1'b1; rd_if.read_address = addr;
        @(negedge clk);
        rd_if.read_en = 1'b0;
        check(name, 32'(rd_if.data_out), 32'(m_read(addr)));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < TOTAL; a++) do_read(32'(a), $sformatf("%s_rd%0d", tag, a));
    endtask

    // written_completed must be low during the final STORE and high the clk after.
    logic pend_wc = 1'b0;
    always @(negedge clk) begin
        if (pend_wc) begin
            check("wc_rise_after_store", 32'(wc), 32'd1);
            pend_wc = 1'b0;
        end
        if (!rst && dut.r_state == ST_STORE && dut.r_count == 32'(TOTAL - 1)) begin
            check("wc_low_in_store", 32'(wc), 32'd0);
            pend_wc = 1'b1;
        end
    end

    initial begin
        vecs[0]  = mk(8'h05, 1, 1, 0); vecs[1]  = mk(8'h0A, 1, 1, 0);
        vecs[2]  = mk(8'hFF, 1, 1, 0); vecs[3]  = mk(8'h3C, 1, 1, 1);
        vecs[4]  = mk(8'h99, 1, 1, 1);
        vecs[5]  = mk(8'h12, 1, 1, 0); vecs[6]  = mk(8'h34, 1, 1, 0);
        vecs[7]  = mk(8'h56, 1, 1, 0); vecs[8]  = mk(8'h78, 1, 1, 1);
        vecs[9]  = mk(8'h11, 1, 0, 0); vecs[10] = mk(8'h22, 1, 1, 0);
        vecs[11] = mk(8'h23, 1, 1, 0); vecs[12] = mk(8'h24, 1, 1, 0);
        vecs[13] = mk(8'h25, 1, 1, 1);
        vecs[14] = mk(8'h55, 0, 1, 0); vecs[15] = mk(8'h66, 1, 1, 0);
        vecs[16] = mk(8'h67, 1, 1, 0); vecs[17] = mk(8'h68, 1, 1, 0);
        vecs[18] = mk(8'h69, 1, 1, 1);
        vecs[19] = mk(8'hA1, 1, 1, 0); vecs[20] = mk(8'hB2, 1, 1, 0);
        vecs[21] = mk(8'hC3, 1, 1, 0); vecs[22] = mk(8'hD4, 1, 1, 1);

        rst = 1'b1; rx_data = 1'b1; write_en = 1'b0;
        rd_if.read_en = 1'b0; rd_if.read_address = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_wc", 32'(wc), 32'd0);
        check("reset_dout", 32'(rd_if.data_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full load and readback.
        run_rows(0, 3);
        read_all("load");

        // Bytes after completion are ignored; reset clears everything.
        run_rows(4, 4);
        read_all("post");
        do_reset();
        check("rst_wc", 32'(wc), 32'd0);
        check("rst_dout", 32'(rd_if.data_out), 32'd0);
        read_all("cleared");

        // Fresh load, out-of-range read, data hold with read_en low.
        run_rows(5, 8);
        read_all("reload");
        do_read(32'd4, "rd_addr4");
        do_read(32'd2, "rd_addr2");
        rd_if.read_address = 32'd0;
        repeat (3) @(negedge clk);
        check("dout_hold", 32'(rd_if.data_out), 32'(m_mem[2]));

        // write_en gating: 0x11 dropped, count starts at 1 after 0x22.
        do_reset();
        run_rows(9, 13);
        do_read(32'd0, "gate_rd0");

        // Framing error, then a glitch, then the load must finish on 0x69.
        do_reset();
        run_rows(14, 15);
        do_read(32'd0, "ferr_rd0");
        do_read(32'd1, "ferr_rd1");
        @(negedge clk); rx_data = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_seen", 32'(dut.w_rx_busy), 32'd1);
        repeat (10) @(negedge clk);
        rx_data = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_gone", 32'(dut.w_rx_busy), 32'd0);
        repeat (100) @(negedge clk);
        check("glitch_wc", 32'(wc), 32'd0);
        run_rows(16, 18);
        read_all("glitch");

        // Reset in the middle of the second byte.
        do_reset();
        apply(8'h10, 1'b1, 1'b1);
        @(negedge clk); rx_data = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx_data = 1'b1; repeat (BIT_CLKS) @(negedge clk);
        rx_data = 1'b0; repeat (BIT_CLKS) @(negedge clk);
        rx_data = 1'b1; repeat (BIT_CLKS / 2) @(negedge clk);
        do_reset();
        check("midrst_wc", 32'(wc), 32'd0);
        check("midrst_dout", 32'(rd_if.data_out), 32'd0);
        run_rows(19, 22);
        read_all("midrst");

        // Randomised frames against the model.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            logic [7:0] d;
            logic       we, stop;
            d    = 8'($urandom);
            we   = ($urandom_range(0, 3) != 0);
            stop = ($urandom_range(0, 6) != 0);
            apply(d, stop, we);
            check($sformatf("rnd_wc%0d", k), 32'(wc), 32'(m_done));
        end
        read_all("rnd");
        do_read(32'd4 + 32'($urandom_range(0, 1000)), "rnd_oob");
        do_read(32'hFFFF_FFFF, "rd_max_addr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
